// File: rtl/motion_decoder_if.sv
// Command/status bundle between the button-code converter and the motion decoder.
// The decoder side (slave) samples the command and drives wheel, heading and location status.
interface motion_decoder_if;
    logic [2:0] motor_mode;
    logic       left_fwd;
    logic       left_rev;
    logic       right_fwd;
    logic       right_rev;
    logic [2:0] heading;
    logic [7:0] loc_x;
    logic [7:0] loc_y;
    logic       moving;
    logic       mode_chg;
    logic       bad_mode;

    modport master (
        output motor_mode,
        input  left_fwd, left_rev, right_fwd, right_rev,
        input  heading, loc_x, loc_y, moving, mode_chg, bad_mode
    );

    modport slave (
        input  motor_mode,
        output left_fwd, left_rev, right_fwd, right_rev,
        output heading, loc_x, loc_y, moving, mode_chg, bad_mode
    );
endinterface

// File: rtl/motion_decoder.sv
// Samples the motion command once per tick and dead-reckons wheel drive, compass heading
// and an 8-bit wrapping (x, y) location for the bot.
module motion_decoder #(
    parameter bit         simulate = 1'b0,
    parameter logic [7:0] INIT_X   = 8'd64,
    parameter logic [7:0] INIT_Y   = 8'd64
) (
    input logic             clk,
    input logic             reset,
    motion_decoder_if.slave bus
);
    typedef enum logic [2:0] {
        STOP = 3'b000,
        R_1X = 3'b001,
        R_2X = 3'b010,
        L_1X = 3'b011,
        L_2X = 3'b100,
        FWD  = 3'b101,
        REV  = 3'b110,
        BAD  = 3'b111
    } mode_t;

    localparam logic [25:0] TERM = simulate ? 26'd5 : 26'd19_999_999;

    logic [25:0] tick_cnt;
    logic        tick;
    mode_t       sample;
    mode_t       mode_q;
    logic [3:0]  wheels_q, wheels_d;
    logic [2:0]  heading_q, heading_d;
    logic [7:0]  x_q, y_q, x_d, y_d;
    logic [1:0]  ux, uy;
    logic [7:0]  step_x, step_y;
    logic        chg_q;
    logic        bad_q;

    assign sample = mode_t'(bus.motor_mode);
    assign tick   = (tick_cnt == TERM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 26'd1;
    end

    // Unit step for the heading held before this tick; 2-bit two's complement per axis.
    always_comb begin
        ux = 2'b00;
        uy = 2'b00;
        unique case (heading_q)
            3'd0: begin ux = 2'b00; uy = 2'b01; end
            3'd1: begin ux = 2'b01; uy = 2'b01; end
            3'd2: begin ux = 2'b01; uy = 2'b00; end
            3'd3: begin ux = 2'b01; uy = 2'b11; end
            3'd4: begin ux = 2'b00; uy = 2'b11; end
            3'd5: begin ux = 2'b11; uy = 2'b11; end
            3'd6: begin ux = 2'b11; uy = 2'b00; end
            3'd7: begin ux = 2'b11; uy = 2'b01; end
        endcase
    end

    assign step_x = {{6{ux[1]}}, ux};
    assign step_y = {{6{uy[1]}}, uy};

    always_comb begin
        wheels_d  = 4'b0000;
        heading_d = heading_q;
        x_d       = x_q;
        y_d       = y_q;
        case (sample)
            R_1X: begin wheels_d = 4'b1000; heading_d = heading_q + 3'd1; end
            R_2X: begin wheels_d = 4'b1001; heading_d = heading_q + 3'd2; end
            L_1X: begin wheels_d = 4'b0010; heading_d = heading_q - 3'd1; end
            L_2X: begin wheels_d = 4'b0110; heading_d = heading_q - 3'd2; end
            FWD: begin
                wheels_d = 4'b1010;
                x_d      = x_q + step_x;
                y_d      = y_q + step_y;
            end
            REV: begin
                wheels_d = 4'b0101;
                x_d      = x_q - step_x;
                y_d      = y_q - step_y;
            end
            default: ;
        endcase
    end

    // mode_chg is the one signal that also moves off-tick, so it drops after a single clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q    <= STOP;
            wheels_q  <= 4'b0000;
            heading_q <= 3'd0;
            x_q       <= INIT_X;
            y_q       <= INIT_Y;
            chg_q     <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            chg_q <= 1'b0;
            if (tick) begin
                mode_q    <= sample;
                chg_q     <= (sample != mode_q);
                wheels_q  <= wheels_d;
                heading_q <= heading_d;
                x_q       <= x_d;
                y_q       <= y_d;
                if (sample == BAD)
                    bad_q <= 1'b1;
            end
        end
    end

    assign bus.left_fwd  = wheels_q[3];
    assign bus.left_rev  = wheels_q[2];
    assign bus.right_fwd = wheels_q[1];
    assign bus.right_rev = wheels_q[0];
    assign bus.heading   = heading_q;
    assign bus.loc_x     = x_q;
    assign bus.loc_y     = y_q;
    assign bus.moving    = (mode_q == FWD) || (mode_q == REV);
    assign bus.mode_chg  = chg_q;
    assign bus.bad_mode  = bad_q;
endmodule
